// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if: D-stage timing codes in, stall/forward/busy controls out.
interface hazard_stall_ctrl_if;
  logic [4:0] rs_D, rt_D, wa_D;
  logic need_rs_D, need_rt_D, hilo_use_D;
  logic [2:0] Tuse_rs_D, Tuse_rt_D, Tnew_D;
  logic [1:0] md_op_D;
  logic stall, md_busy;
  logic [1:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
  modport master(
    output rs_D, rt_D, wa_D, need_rs_D, need_rt_D, hilo_use_D, Tuse_rs_D, Tuse_rt_D, Tnew_D, md_op_D,
    input stall, md_busy, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E
  );
  modport slave(
    input rs_D, rt_D, wa_D, need_rs_D, need_rt_D, hilo_use_D, Tuse_rs_D, Tuse_rt_D, Tnew_D, md_op_D,
    output stall, md_busy, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: Tuse/Tnew stall, bubble and forwarding control with HI/LO busy tracking.
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic clk,
  input logic reset,
  hazard_stall_ctrl_if.slave bus
);
  localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
  logic [4:0] e_wa, e_rs, e_rt, m_wa, w_wa;
  logic [2:0] e_tnew, m_tnew;
  logic [CW-1:0] busy_cnt;
  logic stall_rs, stall_rt, load;
  function automatic logic late(input logic need, input logic [4:0] r, input logic [2:0] tuse,
                                input logic [4:0] wa, input logic [2:0] tnew);
    return need && r != 5'd0 && r == wa && tnew > tuse;
  endfunction
  function automatic logic hit(input logic [4:0] r, input logic [4:0] wa, input logic [2:0] tnew);
    return r != 5'd0 && r == wa && tnew == 3'd0;
  endfunction
  assign stall_rs = late(bus.need_rs_D, bus.rs_D, bus.Tuse_rs_D, e_wa, e_tnew) ||
                    late(bus.need_rs_D, bus.rs_D, bus.Tuse_rs_D, m_wa, m_tnew);
  assign stall_rt = late(bus.need_rt_D, bus.rt_D, bus.Tuse_rt_D, e_wa, e_tnew) ||
                    late(bus.need_rt_D, bus.rt_D, bus.Tuse_rt_D, m_wa, m_tnew);
  assign bus.md_busy = busy_cnt != '0;
  assign bus.stall = stall_rs || stall_rt || (bus.hilo_use_D && bus.md_busy);
  assign load = !bus.stall && (bus.md_op_D == 2'b01 || bus.md_op_D == 2'b10);
  // W results are always ready, so the W slot needs no Tnew of its own
  assign bus.fwd_rs_D = stall_rs ? 2'd0 : hit(bus.rs_D, e_wa, e_tnew) ? 2'd1 :
                        hit(bus.rs_D, m_wa, m_tnew) ? 2'd2 : hit(bus.rs_D, w_wa, 3'd0) ? 2'd3 : 2'd0;
  assign bus.fwd_rt_D = stall_rt ? 2'd0 : hit(bus.rt_D, e_wa, e_tnew) ? 2'd1 :
                        hit(bus.rt_D, m_wa, m_tnew) ? 2'd2 : hit(bus.rt_D, w_wa, 3'd0) ? 2'd3 : 2'd0;
  assign bus.fwd_rs_E = hit(e_rs, m_wa, m_tnew) ? 2'd2 : hit(e_rs, w_wa, 3'd0) ? 2'd3 : 2'd0;
  assign bus.fwd_rt_E = hit(e_rt, m_wa, m_tnew) ? 2'd2 : hit(e_rt, w_wa, 3'd0) ? 2'd3 : 2'd0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      {e_wa, e_tnew, e_rs, e_rt} <= '0;
      {m_wa, m_tnew, w_wa} <= '0;
      busy_cnt <= '0;
    end else begin
      {e_wa, e_tnew, e_rs, e_rt} <= bus.stall ? '0 : {bus.wa_D, bus.Tnew_D, bus.rs_D, bus.rt_D};
      m_wa <= e_wa;
      m_tnew <= e_tnew == 3'd0 ? 3'd0 : e_tnew - 3'd1;
      w_wa <= m_wa;
      busy_cnt <= load ? (bus.md_op_D == 2'b01 ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES)) :
                  busy_cnt != '0 ? busy_cnt - 1'b1 : busy_cnt;
    end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed hazard/forwarding/busy scenarios with hand-computed expectations.
module tb_hazard_stall_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  hazard_stall_ctrl_if h();
  hazard_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut(.clk(clk), .reset(reset), .bus(h));
  always #5 clk = ~clk;
  task automatic drv(input logic [4:0] rs, rt, wa, input logic nrs, nrt,
                     input logic [2:0] urs, urt, tn, input logic [1:0] md, input logic hu);
    @(negedge clk);
    h.rs_D = rs; h.rt_D = rt; h.wa_D = wa; h.need_rs_D = nrs; h.need_rt_D = nrt;
    h.Tuse_rs_D = urs; h.Tuse_rt_D = urt; h.Tnew_D = tn; h.md_op_D = md; h.hilo_use_D = hu;
    #1;
  endtask
  task automatic nop;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
  endtask
  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  initial begin
    h.rs_D = 0; h.rt_D = 0; h.wa_D = 0; h.need_rs_D = 0; h.need_rt_D = 0;
    h.Tuse_rs_D = 0; h.Tuse_rt_D = 0; h.Tnew_D = 0; h.md_op_D = 0; h.hilo_use_D = 0;
    #1;
    chk("rst stall", {3'b0, h.stall}, 0);
    chk("rst md_busy", {3'b0, h.md_busy}, 0);
    chk("rst fwd_rs_D", {2'b0, h.fwd_rs_D}, 0);
    chk("rst fwd_rt_D", {2'b0, h.fwd_rt_D}, 0);
    chk("rst fwd_rs_E", {2'b0, h.fwd_rs_E}, 0);
    chk("rst fwd_rt_E", {2'b0, h.fwd_rt_E}, 0);
    @(negedge clk) reset = 1'b0;
    // lw $1 then add using $1 at Tuse=1
    drv(0, 0, 1, 0, 0, 0, 0, 2, 2'b00, 0);
    chk("t1 lw stall", {3'b0, h.stall}, 0);
    drv(1, 0, 3, 1, 0, 1, 0, 1, 2'b00, 0);
    chk("t1 add stall", {3'b0, h.stall}, 1);
    chk("t1 add fwd_rs_D stalled", {2'b0, h.fwd_rs_D}, 0);
    drv(1, 0, 3, 1, 0, 1, 0, 1, 2'b00, 0);
    chk("t1 add released", {3'b0, h.stall}, 0);
    chk("t1 add fwd_rs_D", {2'b0, h.fwd_rs_D}, 0);
    nop;
    chk("t1 fwd_rs_E W", {2'b0, h.fwd_rs_E}, 3);
    chk("t1 fwd_rt_E", {2'b0, h.fwd_rt_E}, 0);
    // addu $2 then beq $2,$2
    drv(0, 0, 2, 0, 0, 0, 0, 1, 2'b00, 0);
    drv(2, 2, 0, 1, 1, 0, 0, 0, 2'b00, 0);
    chk("t2 beq stall", {3'b0, h.stall}, 1);
    drv(2, 2, 0, 1, 1, 0, 0, 0, 2'b00, 0);
    chk("t2 beq released", {3'b0, h.stall}, 0);
    chk("t2 fwd_rs_D M", {2'b0, h.fwd_rs_D}, 2);
    chk("t2 fwd_rt_D M", {2'b0, h.fwd_rt_D}, 2);
    nop;
    chk("t2 fwd_rs_E W", {2'b0, h.fwd_rs_E}, 3);
    chk("t2 fwd_rt_E W", {2'b0, h.fwd_rt_E}, 3);
    // two jal then jr $31: E wins over M
    drv(0, 0, 31, 0, 0, 0, 0, 0, 2'b00, 0);
    drv(0, 0, 31, 0, 0, 0, 0, 0, 2'b00, 0);
    drv(31, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0);
    chk("t3 jr stall", {3'b0, h.stall}, 0);
    chk("t3 jr fwd_rs_D E", {2'b0, h.fwd_rs_D}, 1);
    nop;
    chk("t3 fwd_rs_E M", {2'b0, h.fwd_rs_E}, 2);
    // writer to $0 never hazards or forwards
    drv(0, 0, 0, 0, 0, 0, 0, 2, 2'b00, 0);
    drv(0, 0, 0, 1, 1, 0, 0, 0, 2'b00, 0);
    chk("t5 stall", {3'b0, h.stall}, 0);
    chk("t5 fwd_rs_D", {2'b0, h.fwd_rs_D}, 0);
    chk("t5 fwd_rt_D", {2'b0, h.fwd_rt_D}, 0);
    nop;
    nop;
    // div then mflo: 10 stall cycles
    drv(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 1);
    chk("t4 div stall", {3'b0, h.stall}, 0);
    chk("t4 div busy before", {3'b0, h.md_busy}, 0);
    for (int i = 1; i <= 10; i++) begin
      drv(0, 0, 5, 0, 0, 0, 0, 1, 2'b00, 1);
      chk($sformatf("t4 div stall c%0d", i), {3'b0, h.stall}, 1);
      chk($sformatf("t4 div busy c%0d", i), {3'b0, h.md_busy}, 1);
    end
    drv(0, 0, 5, 0, 0, 0, 0, 1, 2'b00, 1);
    chk("t4 div stall c11", {3'b0, h.stall}, 0);
    chk("t4 div busy c11", {3'b0, h.md_busy}, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 1);
    chk("t4 mult stall", {3'b0, h.stall}, 0);
    for (int i = 1; i <= 5; i++) begin
      drv(0, 0, 5, 0, 0, 0, 0, 1, 2'b00, 1);
      chk($sformatf("t4 mult stall c%0d", i), {3'b0, h.stall}, 1);
    end
    drv(0, 0, 5, 0, 0, 0, 0, 1, 2'b00, 1);
    chk("t4 mult stall c6", {3'b0, h.stall}, 0);
    chk("t4 mult busy c6", {3'b0, h.md_busy}, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0);
    nop;
    chk("t4 reserved md_op busy", {3'b0, h.md_busy}, 0);
    // reset during div busy cycle 4
    drv(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 1);
    for (int i = 1; i <= 4; i++) drv(0, 0, 5, 0, 0, 0, 0, 1, 2'b00, 1);
    chk("t6 stall c4", {3'b0, h.stall}, 1);
    reset = 1'b1;
    #1;
    chk("t6 rst stall", {3'b0, h.stall}, 0);
    chk("t6 rst busy", {3'b0, h.md_busy}, 0);
    @(negedge clk) reset = 1'b0;
    drv(0, 0, 5, 0, 0, 0, 0, 1, 2'b00, 1);
    chk("t6 mflo after rst", {3'b0, h.stall}, 0);
    // reset during data stall
    drv(0, 0, 1, 0, 0, 0, 0, 2, 2'b00, 0);
    drv(1, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0);
    chk("t6 data stall", {3'b0, h.stall}, 1);
    reset = 1'b1;
    #1;
    chk("t6 rst data stall", {3'b0, h.stall}, 0);
    @(negedge clk) reset = 1'b0;
    drv(1, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0);
    chk("t6 slots cleared stall", {3'b0, h.stall}, 0);
    chk("t6 slots cleared fwd", {2'b0, h.fwd_rs_D}, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
